ir_sequencer: RTL and testbench
===============================

Name: ir_sequencer

Overview:
- Instruction-register and step sequencer for the sm83 core, directly upstream of the decoder.
- Latches the opcode fetched from d_in and advances the M-cycle step counter.
- Resolves conditional-instruction early exit and tracks the CB prefix.
- Handles HALT, owns IME with the delayed-EI rule, and injects interrupt dispatch as a pseudo-opcode the decoder executes.
- Feeds {cb, ir, step} to the decoder; receives done/is_cond/cond/next_cond back from it.

Parameters:
- IRQ_LINES, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad).
- RESET_IR, 8'h00, opcode loaded at reset (NOP, so the first cycle fetches from PC=0).

Ports:
- clk  input  1  core clock, one M-cycle per edge.
- rst_n  input  1  synchronous active-low reset.
- d_in  input  8  data bus; carries the opcode during an instruction's final cycle.
- flags  input  4  {Z,N,H,C} from the core flag register.
- done  input  1  decoder: this step is the instruction's last step (overlapped fetch).
- is_cond  input  1  decoder: the condition is evaluated at this step.
- cond  input  2  condition code: 0=NZ, 1=Z, 2=NC, 3=C.
- next_cond  input  3  step to jump to when the condition fails.
- ei  input  1  decoder strobe: EI executed.
- di  input  1  decoder strobe: DI executed.
- reti  input  1  decoder strobe: RETI executed.
- irq_en  input  IRQ_LINES  IE register.
- irq_flag  input  IRQ_LINES  IF register.
- ir  output  8  current opcode or pseudo-opcode.
- cb  output  1  current ir is a CB-page opcode.
- step  output  3  current step within the instruction.
- halted  output  1  core is in HALT.
- ime  output  1  interrupt master enable.
- irq_ack  output  IRQ_LINES  one-hot, one-cycle clear strobe for the serviced IF bit.
- irq_vector  output  8  low byte of the vector (8'h40 + 8*index); valid while ir==IRQ_OPCODE.

Behaviour:
- Reset (rst_n=0 at a clk edge): ir=RESET_IR, cb=0, step=0, state=RUN, ime=0, ei_pending=0, irq_ack=0, irq_vector=8'h40, halted=0. Reset mid-instruction or mid-dispatch abandons it completely.
- pending = irq_en & irq_flag. idx = lowest set bit of pending (bit 0 has highest priority).
- States: RUN and HALT.
- RUN, precedence done > condition fail > increment:
  - done=1 and ir==8'h76, cb=0, pending==0: enter HALT. ir and step hold; cb=0.
  - done=1 and ime=1 and pending!=0 (HALT opcode included): ir<=IRQ_OPCODE, cb<=0, step<=0; irq_ack<=onehot(idx) for exactly 1 cycle; irq_vector<=8'h40+8*idx; ime<=0. d_in is discarded; the decoder does not advance PC on this fetch.
  - done=1, all other cases: ir<=d_in, step<=0, cb<=(ir==8'hCB && !cb).
  - done=0, is_cond=1, condition false: step<=next_cond.
  - Otherwise: step<=step+1. Wrap 7->0 is legal but never exercised by valid decoder tables.
- Condition true: NZ=!Z, Z=Z, NC=!C, C=C.
- HALT:
  - halted=1; step=0; no fetch.
  - Exit when pending!=0, on the cycle after pending is seen.
  - ime=1: dispatch exactly as above.
  - ime=0: state<=RUN, ir<=d_in, step<=0 (no halt bug).
  - halted deasserts on the exit edge.
- IME:
  - di or dispatch: ime<=0 and ei_pending<=0 the same cycle.
  - reti: ime<=1 immediately.
  - ei: ei_pending<=1. ime<=1 on the edge where the next instruction's done is sampled, so the instruction after EI always completes before any dispatch.
  - ei and di together: di wins.
- Width rules: step is modulo 8. irq_vector is formed combinationally into a registered output; no carry beyond 8 bits (max 8'h60).

Decomposition:
- Shared package (alongside the decoder typedefs):
  - cond_t enum (NZ, Z, NC, C).
  - seq_state_t (RUN, HALT).
  - IRQ_OPCODE = 8'hD3 (an unused opcode).
  - HALT_OPCODE = 8'h76, CB_OPCODE = 8'hCB, IRQ_BASE = 8'h40.
- One sub-module, irq_prio: combinational priority encoder from pending to {any, onehot, index}.

Test Plan:
- Reset with d_in=8'h3E, then done=1 for one cycle -> ir=8'h3E, step=0, cb=0. Next cycle with done=0 -> step=1.
- JR NZ with is_cond=1 at step 1, flags Z=1, next_cond=3 -> step goes 1->3. Same with Z=0 -> step goes 1->2.
- Fetch 8'hCB then 8'hCB on consecutive dones -> first gives ir=CB, cb=0; second gives ir=CB, cb=1; a third done with d_in=8'h00 -> cb=0.
- HALT with ime=0, irq_flag=0 -> halted=1, step stays 0. Then irq_en=irq_flag=5'b00100 -> next cycle halted=0, ir=d_in, irq_ack=0.
- ime=1, pending=5'b10100, done=1 -> ir=8'hD3, irq_ack=5'b00100 for 1 cycle, irq_vector=8'h50, ime=0.
- EI then an instruction with pending=5'b00001 -> no dispatch at EI's done; ime=1 and dispatch at the following instruction's done with vector 8'h40. EI and DI together -> ime stays 0.

Source files
------------

// File: rtl/ir_sequencer_pkg.sv
// Shared types and constants for the sm83 instruction-register / step sequencer
// and the decoder that consumes {cb, ir, step}.
//
// Contents:
//   cond_t       - condition codes carried on the decoder's cond field
//   seq_state_t  - sequencer run state
//   *_OPCODE     - opcodes the sequencer treats specially
//   IRQ_BASE     - low byte of the first interrupt vector
//   cond_met()   - evaluates a condition code against the Z and C flags

package ir_sequencer_pkg;

    typedef enum logic [1:0] {
        CondNz = 2'd0,
        CondZ  = 2'd1,
        CondNc = 2'd2,
        CondC  = 2'd3
    } cond_t;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } seq_state_t;

    // Unused sm83 opcode, repurposed so the decoder can run interrupt dispatch
    // through its normal microcode tables.
    localparam logic [7:0] IRQ_OPCODE  = 8'hD3;
    localparam logic [7:0] HALT_OPCODE = 8'h76;
    localparam logic [7:0] CB_OPCODE   = 8'hCB;
    localparam logic [7:0] IRQ_BASE    = 8'h40;

    // True when the branch/call/return condition holds.
    function automatic logic cond_met(input cond_t c, input logic z, input logic cy);
        logic met;
        unique case (c)
            CondNz:  met = !z;
            CondZ:   met = z;
            CondNc:  met = !cy;
            CondC:   met = cy;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ir_sequencer_irq_prio.sv
// Combinational fixed-priority encoder for pending interrupts.
// Bit 0 has the highest priority.
//
// Ports:
//   pending  in   LINES  IE & IF
//   any      out  1      at least one pending source
//   onehot   out  LINES  lowest set bit of pending (zero when none)
//   index    out  IDX_W  position of that bit (zero when none)

module irq_prio
    import ir_sequencer_pkg::*;
#(
    parameter int unsigned LINES = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [LINES-1:0] pending,
    output logic             any,
    output logic [LINES-1:0] onehot,
    output logic [IDX_W-1:0] index
);

    assign any = |pending;

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = pending & (~pending + LINES'(1));

    always_comb begin
        index = '0;
        // Walk from the top so the lowest set bit is the last one written.
        for (int i = int'(LINES) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ir_sequencer.sv
// Instruction register and M-cycle step sequencer for the sm83 core.
// Latches the opcode on an instruction's last step (overlapped fetch), steps
// through the instruction, takes early exits on failed conditions, tracks the
// CB prefix page, implements HALT, owns IME (with the one-instruction EI delay)
// and injects interrupt dispatch as IRQ_OPCODE.
//
// Ports:
//   clk, rst_n    clock (one M-cycle per edge), synchronous active-low reset
//   d_in          data bus, carries the opcode on an instruction's last step
//   flags         {Z,N,H,C}
//   done          decoder: current step is the instruction's last
//   is_cond       decoder: condition evaluated this step
//   cond          decoder: condition code (cond_t)
//   next_cond     decoder: step to jump to when the condition fails
//   ei, di, reti  decoder strobes
//   irq_en        IE register
//   irq_flag      IF register
//   ir, cb, step  opcode / CB page / step fed to the decoder
//   halted        core is in HALT
//   ime           interrupt master enable
//   irq_ack       one-cycle one-hot IF clear strobe
//   irq_vector    low byte of the dispatch vector, valid while ir == IRQ_OPCODE

module ir_sequencer
    import ir_sequencer_pkg::*;
#(
    parameter int unsigned IRQ_LINES = 5,
    parameter logic [7:0]  RESET_IR  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           d_in,
    input  logic [3:0]           flags,
    input  logic                 done,
    input  logic                 is_cond,
    input  logic [1:0]           cond,
    input  logic [2:0]           next_cond,
    input  logic                 ei,
    input  logic                 di,
    input  logic                 reti,
    input  logic [IRQ_LINES-1:0] irq_en,
    input  logic [IRQ_LINES-1:0] irq_flag,
    output logic [7:0]           ir,
    output logic                 cb,
    output logic [2:0]           step,
    output logic                 halted,
    output logic                 ime,
    output logic [IRQ_LINES-1:0] irq_ack,
    output logic [7:0]           irq_vector
);

    localparam int unsigned IDX_W = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;

    seq_state_t           state;
    logic                 ei_pending;

    logic [IRQ_LINES-1:0] pending;
    logic                 irq_any;
    logic [IRQ_LINES-1:0] irq_onehot;
    logic [IDX_W-1:0]     irq_index;
    logic [7:0]           vector_next;
    logic                 take_irq;
    logic                 cond_ok;

    // N and H never affect sequencing.
    logic                 unused_flags;
    assign unused_flags = ^flags[2:1];

    assign pending = irq_en & irq_flag;

    irq_prio #(
        .LINES (IRQ_LINES),
        .IDX_W (IDX_W)
    ) u_irq_prio (
        .pending (pending),
        .any     (irq_any),
        .onehot  (irq_onehot),
        .index   (irq_index)
    );

    // 8 bytes per vector; wraps within 8 bits by construction.
    assign vector_next = IRQ_BASE + (8'(irq_index) << 3);

    assign cond_ok = cond_met(cond_t'(cond), flags[3], flags[0]);

    // Dispatch replaces an instruction boundary fetch, or ends HALT.
    assign take_irq = ime && irq_any && ((state == StHalt) || done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StRun;
            ir         <= RESET_IR;
            cb         <= 1'b0;
            step       <= 3'd0;
            halted     <= 1'b0;
            ime        <= 1'b0;
            ei_pending <= 1'b0;
            irq_ack    <= '0;
            irq_vector <= IRQ_BASE;
        end else begin
            irq_ack <= '0;

            // IME bookkeeping; later statements take precedence.
            // A pending EI becomes effective at the next instruction boundary,
            // after the dispatch decision for that boundary has been made.
            if ((state == StRun) && done && ei_pending) begin
                ime        <= 1'b1;
                ei_pending <= 1'b0;
            end
            if (ei) begin
                ei_pending <= 1'b1;
            end
            if (reti) begin
                ime <= 1'b1;
            end
            if (di || take_irq) begin
                ime        <= 1'b0;
                ei_pending <= 1'b0;
            end

            unique case (state)
                StRun: begin
                    if (done) begin
                        if (ir == HALT_OPCODE && !cb && !irq_any) begin
                            // ir and step hold while halted.
                            state  <= StHalt;
                            halted <= 1'b1;
                            cb     <= 1'b0;
                        end else if (!take_irq) begin
                            ir   <= d_in;
                            step <= 3'd0;
                            // Only a CB fetched from the base page opens the CB page.
                            cb   <= (ir == CB_OPCODE) && !cb;
                        end
                    end else if (is_cond && !cond_ok) begin
                        step <= next_cond;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                StHalt: begin
                    step <= 3'd0;
                    if (irq_any) begin
                        state  <= StRun;
                        halted <= 1'b0;
                        // With IME clear the core just resumes on the next opcode.
                        if (!take_irq) begin
                            ir <= d_in;
                            cb <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= StRun;
                end
            endcase

            // Dispatch overrides the fetch; d_in is discarded.
            if (take_irq) begin
                state      <= StRun;
                halted     <= 1'b0;
                ir         <= IRQ_OPCODE;
                cb         <= 1'b0;
                step       <= 3'd0;
                irq_ack    <= irq_onehot;
                irq_vector <= vector_next;
            end
        end
    end

endmodule

// File: tb/tb_ir_sequencer.sv
// Bench for ir_sequencer: a directed vector table walking the main scenarios,
// two short hand-written sequences, then randomized traffic against a
// behavioural model.

module tb_ir_sequencer;

    typedef struct packed {
        logic       rst_n;
        logic [7:0] d_in;
        logic [3:0] flags;
        logic       done;
        logic       is_cond;
        logic [1:0] cond;
        logic [2:0] next_cond;
        logic       ei;
        logic       di;
        logic       reti;
        logic [4:0] en;
        logic [4:0] flg;
    } in_t;

    typedef struct packed {
        logic [7:0] ir;
        logic       cb;
        logic [2:0] step;
        logic       halted;
        logic       ime;
        logic [4:0] ack;
        logic [7:0] vec;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_in;
    logic [3:0] flags;
    logic       done;
    logic       is_cond;
    logic [1:0] cond;
    logic [2:0] next_cond;
    logic       ei;
    logic       di;
    logic       reti;
    logic [4:0] irq_en;
    logic [4:0] irq_flag;
    logic [7:0] ir;
    logic       cb;
    logic [2:0] step;
    logic       halted;
    logic       ime;
    logic [4:0] irq_ack;
    logic [7:0] irq_vector;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state.
    logic [7:0] m_ir;
    bit         m_cb;
    int         m_step;
    bit         m_halted;
    bit         m_ime;
    bit         m_eip;
    logic [4:0] m_ack;
    logic [7:0] m_vec;

    row_t rows[$];

    always #5 clk = ~clk;

    ir_sequencer #(
        .IRQ_LINES (5),
        .RESET_IR  (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .flags      (flags),
        .done       (done),
        .is_cond    (is_cond),
        .cond       (cond),
        .next_cond  (next_cond),
        .ei         (ei),
        .di         (di),
        .reti       (reti),
        .irq_en     (irq_en),
        .irq_flag   (irq_flag),
        .ir         (ir),
        .cb         (cb),
        .step       (step),
        .halted     (halted),
        .ime        (ime),
        .irq_ack    (irq_ack),
        .irq_vector (irq_vector)
    );

    function automatic in_t ii(int r, int d, int fl, int dn, int ic, int c, int nc,
                               int e, int dd, int rt, int en, int fg);
        in_t v;
        v.rst_n = 1'(r);  v.d_in = 8'(d);  v.flags = 4'(fl);  v.done = 1'(dn);
        v.is_cond = 1'(ic);  v.cond = 2'(c);  v.next_cond = 3'(nc);
        v.ei = 1'(e);  v.di = 1'(dd);  v.reti = 1'(rt);  v.en = 5'(en);  v.flg = 5'(fg);
        return v;
    endfunction

    function automatic out_t oo(int i_r, int c, int s, int h, int im, int a, int v);
        out_t o;
        o.ir = 8'(i_r);  o.cb = 1'(c);  o.step = 3'(s);  o.halted = 1'(h);
        o.ime = 1'(im);  o.ack = 5'(a);  o.vec = 8'(v);
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        row_t r;
        r.i = i;
        r.o = o;
        rows.push_back(r);
    endtask

    task automatic drive(input in_t v);
        rst_n = v.rst_n;  d_in = v.d_in;  flags = v.flags;  done = v.done;
        is_cond = v.is_cond;  cond = v.cond;  next_cond = v.next_cond;
        ei = v.ei;  di = v.di;  reti = v.reti;  irq_en = v.en;  irq_flag = v.flg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t sample();
        out_t o;
        o = {ir, cb, step, halted, ime, irq_ack, irq_vector};
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ir=%h cb=%0d step=%0d halted=%0d ime=%0d ack=%b vec=%h; want ir=%h cb=%0d step=%0d halted=%0d ime=%0d ack=%b vec=%h",
                     name, got.ir, got.cb, got.step, got.halted, got.ime, got.ack, got.vec,
                     exp.ir, exp.cb, exp.step, exp.halted, exp.ime, exp.ack, exp.vec);
        end
    endtask

    // Reference: one clock edge applied to the model from the current inputs.
    task automatic model_edge();
        int  idx;
        bit  have;
        bit  fire;
        bit  flag_bit;
        bit  holds;
        logic [4:0] pend;
        pend = irq_en & irq_flag;
        idx = -1;
        for (int i = 4; i >= 0; i--) if (pend[i]) idx = i;
        have = (idx >= 0);
        if (!rst_n) begin
            m_ir = 8'h00;  m_cb = 0;  m_step = 0;  m_halted = 0;
            m_ime = 0;  m_eip = 0;  m_ack = 5'b0;  m_vec = 8'h40;
            return;
        end
        m_ack = 5'b0;
        fire = m_ime && have && (m_halted || done);
        // cond[1] selects C over Z, cond[0] selects the set polarity.
        flag_bit = cond[1] ? flags[0] : flags[3];
        holds = (flag_bit == cond[0]);
        if (!m_halted && done && m_eip) begin m_ime = 1; m_eip = 0; end
        if (ei) m_eip = 1;
        if (reti) m_ime = 1;
        if (di || fire) begin m_ime = 0; m_eip = 0; end
        if (fire) begin
            m_halted = 0;  m_ir = 8'hD3;  m_cb = 0;  m_step = 0;
            m_ack = 5'(1 << idx);
            m_vec = 8'(64 + 8 * idx);
        end else if (m_halted) begin
            m_step = 0;
            if (have) begin m_halted = 0; m_ir = d_in; m_cb = 0; end
        end else if (done) begin
            if (m_ir == 8'h76 && !m_cb && !have) begin
                m_halted = 1;
                m_cb = 0;
            end else begin
                m_cb = (m_ir == 8'hCB) && !m_cb;
                m_ir = d_in;
                m_step = 0;
            end
        end else if (is_cond && !holds) begin
            m_step = int'(next_cond);
        end else begin
            m_step = (m_step + 1) % 8;
        end
    endtask

    function automatic out_t model_out();
        return oo(int'(m_ir), int'(m_cb), m_step, int'(m_halted), int'(m_ime),
                  int'(m_ack), int'(m_vec));
    endfunction

    initial begin
        //  rst  d_in   fl dn ic c nc ei di rt en     flg        ir   cb st h im ack   vec
        add(ii(0, 8'h3E, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h3E, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h3E, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h3E, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h3E, 0, 1, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 8, 0, 1, 0, 3, 0, 0, 0, 5'h00, 5'h00), oo(8'h3E, 0, 3, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h20, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h20, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h20, 0, 1, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 0, 1, 0, 3, 0, 0, 0, 5'h00, 5'h00), oo(8'h20, 0, 2, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'hCB, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hCB, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'hCB, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hCB, 1, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h76, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h76, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h12, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h76, 0, 0, 1, 0, 5'h00, 8'h40));
        add(ii(1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h76, 0, 0, 1, 0, 5'h00, 8'h40));
        add(ii(1, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 5'h04, 5'h04), oo(8'h5A, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 5'h00, 5'h00), oo(8'h00, 0, 0, 0, 1, 5'h00, 8'h40));
        add(ii(1, 8'h77, 0, 1, 0, 0, 0, 0, 0, 0, 5'h14, 5'h14), oo(8'hD3, 0, 0, 0, 0, 5'h04, 8'h50));
        add(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hD3, 0, 1, 0, 0, 5'h00, 8'h50));
        add(ii(1, 8'hFB, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hFB, 0, 0, 0, 0, 5'h00, 8'h50));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0, 5'h01, 5'h01), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h50));
        add(ii(1, 8'h04, 0, 1, 0, 0, 0, 0, 0, 0, 5'h01, 5'h01), oo(8'h04, 0, 0, 0, 1, 5'h00, 8'h50));
        add(ii(1, 8'h05, 0, 1, 0, 0, 0, 0, 0, 0, 5'h01, 5'h01), oo(8'hD3, 0, 0, 0, 0, 5'h01, 8'h40));
        add(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hD3, 0, 1, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 1, 1, 0, 5'h00, 5'h00), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 5'h01, 5'h01), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 5'h01, 5'h01), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        add(ii(1, 8'h76, 0, 1, 0, 0, 0, 0, 0, 1, 5'h00, 5'h00), oo(8'h76, 0, 0, 0, 1, 5'h00, 8'h40));
        add(ii(1, 8'h11, 0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h76, 0, 0, 1, 1, 5'h00, 8'h40));
        add(ii(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0, 5'h08, 5'h08), oo(8'hD3, 0, 0, 0, 0, 5'h08, 8'h58));
        add(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'hD3, 0, 1, 0, 0, 5'h00, 8'h58));
        add(ii(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));

        drive(ii(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        foreach (rows[k]) begin
            drive(rows[k].i);
            tick();
            check($sformatf("vec%0d", k), sample(), rows[k].o);
        end

        // Step counter wraps 7 -> 0.
        drive(ii(1, 8'h3E, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) tick();
        check("wrap_step7", sample(), oo(8'h3E, 0, 7, 0, 0, 5'h00, 8'h40));
        tick();
        check("wrap_step0", sample(), oo(8'h3E, 0, 0, 0, 0, 5'h00, 8'h40));

        // Reset in the middle of a dispatch abandons it.
        drive(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tick();
        drive(ii(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 5'h10, 5'h10));
        tick();
        check("dispatch_j", sample(), oo(8'hD3, 0, 0, 0, 0, 5'h10, 8'h60));
        drive(ii(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h10, 5'h10));
        tick();
        check("rst_mid_dispatch", sample(), oo(8'h00, 0, 0, 0, 0, 5'h00, 8'h40));
        drive(ii(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 5'h10, 5'h10));
        tick();
        check("after_rst", sample(), oo(8'h00, 0, 1, 0, 0, 5'h00, 8'h40));

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int pick;
            rst_n = (k == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            pick = int'($urandom_range(0, 5));
            d_in = (pick == 0) ? 8'h76 : (pick == 1) ? 8'hCB : 8'($urandom);
            flags = 4'($urandom);
            done = ($urandom_range(0, 2) == 0);
            is_cond = ($urandom_range(0, 3) == 0);
            cond = 2'($urandom);
            next_cond = 3'($urandom);
            ei = ($urandom_range(0, 9) == 0);
            di = ($urandom_range(0, 11) == 0);
            reti = ($urandom_range(0, 11) == 0);
            irq_en = 5'($urandom);
            irq_flag = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
            model_edge();
            tick();
            check($sformatf("rand%0d", k), sample(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
